// File: rtl/mdu_iter_pkg.sv
// mdu_iter_pkg
//   Shared definitions for the iterative multiply/divide unit and the decoder
//   that feeds it: RV M-extension funct3 encodings, FSM state encodings and
//   operand-signedness helpers.
package mdu_iter_pkg;

  // RV funct3 encodings for the M extension
  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  // FSM state encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // rs1 is signed for MULH, MULHSU, DIV, REM
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  // rs2 is signed for MULH, DIV, REM (MULHSU keeps rs2 unsigned)
  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if
//   Request/response bundle between the execute stage and the mul/div unit.
//   Request side : in_valid/in_ready handshake carrying op, a, b.
//   Response side: out_valid/out_ready handshake carrying result.
//   master = the core (issues ops, consumes results); slave = the unit.
interface mdu_iter_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/mdu_negate.sv
// mdu_negate
//   Combinational conditional two's-complement: y = neg ? -x : x.
//   Ports: x (W) value in, neg (1) negate request, y (W) value out.
module mdu_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? (~x + W'(1)) : x;
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter
//   Iterative radix-2 RV M-extension multiply/divide unit. One op in flight.
//   Flow: IDLE -(accept)-> BUSY (XLEN cycles) -> SIGN (1 cycle) -> DONE.
//   Ports:
//     clk   in  clock, rising edge
//     rst   in  synchronous active-high reset (beats flush and handshakes)
//     flush in  kill in-flight op / pending result; result register kept
//     bus   slave modport of mdu_iter_if (in_valid/in_ready/op/a/b,
//           out_valid/out_ready/result)
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  mdu_iter_if.slave  bus
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_b_abs;
  logic              r_neg;
  // mul: {partial product high, multiplier being shifted out / product low}
  // div: {partial remainder, dividend being shifted out / quotient bits}
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;
  logic              r_out_valid;

  // ---------------- accept-time decode ----------------
  logic            w_a_neg_in, w_b_neg_in;
  logic [XLEN-1:0] w_a_abs, w_b_abs;
  logic            w_is_div, w_is_rem, w_b_zero, w_ovf, w_special;
  logic [XLEN-1:0] w_spec_quo, w_spec_rem;
  logic            w_neg_in;

  assign w_a_neg_in = op_a_signed(bus.op) & bus.a[XLEN-1];
  assign w_b_neg_in = op_b_signed(bus.op) & bus.b[XLEN-1];

  mdu_negate #(.W(XLEN)) u_abs_a (.x(bus.a), .neg(w_a_neg_in), .y(w_a_abs));
  mdu_negate #(.W(XLEN)) u_abs_b (.x(bus.b), .neg(w_b_neg_in), .y(w_b_abs));

  assign w_is_div  = bus.op[2];
  assign w_is_rem  = (bus.op == MDU_REM) || (bus.op == MDU_REMU);
  assign w_b_zero  = (bus.b == '0);
  assign w_ovf     = ((bus.op == MDU_DIV) || (bus.op == MDU_REM)) &&
                     (bus.a == MIN_INT) && (bus.b == '1);
  assign w_special = w_is_div && (w_b_zero || w_ovf);

  // Special-case answers are preloaded into the accumulator halves so the
  // normal SIGN-stage selection (with no negation) delivers them.
  assign w_spec_quo = w_b_zero ? '1 : bus.a;
  assign w_spec_rem = w_b_zero ? bus.a : '0;

  // Remainder follows the sign of a; product and quotient follow a^b.
  assign w_neg_in = w_is_rem ? w_a_neg_in : (w_a_neg_in ^ w_b_neg_in);

  // ---------------- iteration datapath ----------------
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_div_shift, w_div_diff;
  logic              w_div_ok;
  logic [2*XLEN-1:0] w_div_next;

  // Shift-add: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b_abs} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Restoring division: bring in the next dividend bit, trial-subtract with a
  // single XLEN+1 subtractor, keep the difference only if it did not borrow.
  assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b_abs};
  assign w_div_ok    = ~w_div_diff[XLEN];
  assign w_div_next  = {(w_div_ok ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0]),
                        r_acc[XLEN-2:0], w_div_ok};

  // ---------------- sign correction / result select ----------------
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_div_src, w_div_fix;
  logic [XLEN-1:0]   w_sel;

  mdu_negate #(.W(2*XLEN)) u_fix_prod (.x(r_acc), .neg(r_neg), .y(w_prod_fix));

  // op[1] picks remainder (REM/REMU) over quotient (DIV/DIVU)
  assign w_div_src = r_op[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
  mdu_negate #(.W(XLEN)) u_fix_div (.x(w_div_src), .neg(r_neg), .y(w_div_fix));

  always_comb begin
    w_sel = w_div_fix;
    case (r_op)
      MDU_MUL:                        w_sel = w_prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: w_sel = w_prod_fix[2*XLEN-1:XLEN];
      default:                        w_sel = w_div_fix;
    endcase
  end

  // ---------------- control ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= MDU_MUL;
      r_b_abs     <= '0;
      r_neg       <= 1'b0;
      r_acc       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_op    <= bus.op;
            r_b_abs <= w_b_abs;
            r_cnt   <= '0;
            if (w_special) begin
              // Skip the iterations; SIGN still takes its one cycle so the
              // result appears two cycles after accept.
              r_neg   <= 1'b0;
              r_acc   <= {w_spec_rem, w_spec_quo};
              r_state <= S_SIGN;
            end else begin
              r_neg   <= w_neg_in;
              r_acc   <= {{XLEN{1'b0}}, w_a_abs};
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_acc <= r_op[2] ? w_div_next : w_mul_next;
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_SIGN;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_SIGN: begin
          r_result    <= w_sel;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;

endmodule
